// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: controller states, register constants and
// the per-stage control bundles used by the hazard unit and pipeline registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hc_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // ID-stage control word; pipeline registers load ID_CTRL_NOP on flush/bubble
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src;
    } id_ctrl_t;

    localparam id_ctrl_t ID_CTRL_NOP = '0;

    typedef struct packed {
        logic stall;
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } hc_ctrl_t;

    localparam hc_ctrl_t HC_RUN = '{stall: 1'b0, pc_write: 1'b1, if_id_write: 1'b1,
                                    id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                    mem_wb_bubble: 1'b0};

    localparam hc_ctrl_t HC_FREEZE = '{stall: 1'b0, pc_write: 1'b0, if_id_write: 1'b0,
                                       id_ex_write: 1'b0, ex_mem_write: 1'b0,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                       mem_wb_bubble: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline status in, sequencing strobes out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             stall;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, dmem_ready,
        input  stall, pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, dmem_ready,
        output stall, pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use stall, taken-branch flush, data-memory freeze
// with timeout, and a stall-cycle counter.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    hc_state_t       r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_mem_err;
    logic            w_freeze;
    logic            w_load_use;
    hc_ctrl_t        w_ctrl;

    always_comb begin
        w_freeze   = (r_state == MEM_WAIT) || (r_state == ERR) ||
                     ((r_state == RUN) && bus.mem_req && !bus.dmem_ready);
        w_load_use = bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                     ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
        w_ctrl = HC_RUN;
        // A frozen branch stays in EX, so its flush lands on the first unfrozen cycle
        if (w_freeze) begin
            w_ctrl = HC_FREEZE;
        end else if (bus.ex_branch_taken) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.stall       = 1'b1;
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.mem_req && !bus.dmem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                        r_state   <= ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ERR;
                    r_mem_err <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!w_ctrl.pc_write),
        .count (bus.stall_cycles)
    );

    assign bus.stall         = w_ctrl.stall;
    assign bus.pc_write      = w_ctrl.pc_write;
    assign bus.if_id_write   = w_ctrl.if_id_write;
    assign bus.id_ex_write   = w_ctrl.id_ex_write;
    assign bus.ex_mem_write  = w_ctrl.ex_mem_write;
    assign bus.if_id_flush   = w_ctrl.if_id_flush;
    assign bus.id_ex_flush   = w_ctrl.id_ex_flush;
    assign bus.mem_wb_bubble = w_ctrl.mem_wb_bubble;
    assign bus.mem_err       = r_mem_err;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level
// reference model built from the hazard/freeze rules.
module tb_hazard_ctrl;
    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // reference model: outstanding-access length, sticky error, stall count
    int   m_pend;
    logic m_err;
    int   m_stalls;
    logic [7:0] e_cur;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // order: stall, pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, bubble
    function automatic logic [7:0] exp_ctrl();
        bit frz;
        bit lu;
        frz = m_err || (m_pend > 0) || (bus.mem_req && !bus.dmem_ready);
        lu  = bus.ex_mem_read && (bus.ex_rd != 0) &&
              ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
               (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        if (frz)                      return 8'b0000_0001;
        else if (bus.ex_branch_taken) return 8'b0111_1110;
        else if (lu)                  return 8'b1001_1000;
        else                          return 8'b0111_1000;
    endfunction

    task automatic model_reset();
        m_pend   = 0;
        m_err    = 1'b0;
        m_stalls = 0;
    endtask

    task automatic model_edge();
        if (!e_cur[6]) m_stalls = (m_stalls >= CMAX) ? CMAX : m_stalls + 1;
        if (!m_err) begin
            if (m_pend == 0) begin
                if (bus.mem_req && !bus.dmem_ready) m_pend = 1;
            end else if (bus.dmem_ready) begin
                m_pend = 0;
            end else begin
                m_pend++;
                if (m_pend >= TO) begin
                    m_err  = 1'b1;
                    m_pend = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] obs;
        obs = {bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_write,
               bus.ex_mem_write, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};
        e_cur = exp_ctrl();
        total++;
        assert (obs === e_cur) else begin
            bad++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e_cur);
        end
        total++;
        assert (bus.mem_err === m_err) else begin
            bad++;
            $error("FAIL %s mem_err observed=%b expected=%b", tag, bus.mem_err, m_err);
        end
        total++;
        assert (bus.stall_cycles === CW'(m_stalls)) else begin
            bad++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, bus.stall_cycles, m_stalls);
        end
    endtask

    task automatic check_cnt(input string tag, input int want);
        total++;
        assert (bus.stall_cycles === CW'(want)) else begin
            bad++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, bus.stall_cycles, want);
        end
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit mr, input bit br,
                          input bit mreq, input bit rdy);
        bus.id_rs1          = 5'(rs1);
        bus.id_rs2          = 5'(rs2);
        bus.id_use_rs1      = u1;
        bus.id_use_rs2      = u2;
        bus.ex_rd           = 5'(rd);
        bus.ex_mem_read     = mr;
        bus.ex_branch_taken = br;
        bus.mem_req         = mreq;
        bus.dmem_ready      = rdy;
    endtask

    task automatic nop_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // inputs are applied just after a rising edge; check mid-cycle, then advance
    task automatic cycle(input string tag);
        #4;
        check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nop_in();
        #2;
        model_reset();
        check("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        e_cur = '0;
        nop_in();
        do_reset();

        // load-use stall for one cycle
        set_in(5, 7, 1, 0, 5, 1, 0, 0, 1); cycle("load_use");
        check_cnt("load_use_cnt", 1);
        nop_in();                          cycle("after_lu");

        // x0 destination and unused rs2 never stall
        set_in(0, 0, 1, 1, 0, 1, 0, 0, 1); cycle("lu_x0");
        set_in(9, 5, 1, 0, 5, 1, 0, 0, 1); cycle("lu_rs2_unused");
        set_in(9, 5, 0, 1, 5, 1, 0, 0, 1); cycle("lu_rs2");

        // branch beats load-use
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 1); cycle("br_vs_lu");
        nop_in();                          cycle("after_br");

        // three wait cycles then ready: four frozen cycles
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) cycle("mem_wait");
        bus.dmem_ready = 1'b1;             cycle("mem_done");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("mem_resume");
        check_cnt("mem_wait_cnt", 4);

        // timeout to sticky error, then reset clears it
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (6) cycle("timeout");
        total++;
        assert (bus.mem_err === 1'b1) else begin
            bad++;
            $error("FAIL timeout_err observed=%b expected=1", bus.mem_err);
        end
        set_in(3, 0, 1, 0, 3, 1, 1, 0, 1); cycle("err_frozen");
        do_reset();

        // branch held across a freeze flushes exactly once
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) cycle("br_frozen");
        bus.dmem_ready = 1'b1;             cycle("br_frozen_rdy");
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1); cycle("br_release");
        nop_in();                          cycle("br_done");

        // counter saturation
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) cycle("saturate");
        check_cnt("sat_cnt", CMAX);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 9) < 7));
            cycle("random");
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It detects load-use hazards, flushes wrong-path instructions on taken branches, and freezes the pipeline while data memory is busy. Its `stall` output drives the control unit's `stall` input, which bubbles ID/EX. It also produces the per-stage write-enable and flush strobes, a memory-timeout error, and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before error (must be ≥2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage holds a valid load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall  out  1  to control unit; zeroes ID controls (bubble).
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- ex_mem_write  out  1  EX/MEM register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to NOP.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- mem_err  out  1  sticky timeout error.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
  - Outputs take the RUN, no-hazard values: write enables 1; stall, flushes, and bubble 0.
- States: RUN, MEM_WAIT, ERR. The state encoding lives in the package.
- freeze = (state==MEM_WAIT) || (state==RUN && mem_req && !dmem_ready) || (state==ERR).
- load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Priority, evaluated combinationally each cycle:
  - **freeze:** pc_write, if_id_write, id_ex_write, ex_mem_write=0; mem_wb_bubble=1; stall=0; flushes=0.
  - **else ex_branch_taken:** if_id_flush=1, id_ex_flush=1, pc_write=1, stall=0. Load-use is suppressed because the ID instruction is wrong-path.
  - **else load_use:** pc_write=0, if_id_write=0, stall=1, id_ex_write=1 (the bubble enters ID/EX). This lasts exactly 1 cycle, because the load advances to MEM.
  - **else:** all write enables 1; stall, flushes, and bubble 0.
- A branch taken during a freeze is held in EX. Its flush is applied on the first unfrozen cycle, never lost and never applied twice.
- Transitions:
  - RUN→MEM_WAIT when mem_req && !dmem_ready; wait_cnt←1.
  - MEM_WAIT→RUN when dmem_ready; wait_cnt←0. The freeze is still asserted in that cycle, and the pipeline advances the next cycle.
  - MEM_WAIT with !dmem_ready: if wait_cnt==MEM_TIMEOUT-1 → ERR and mem_err←1; else wait_cnt+1.
  - mem_req dropping in MEM_WAIT is a protocol violation. The state is held regardless.
  - ERR is terminal until reset: full freeze, mem_err=1.
- mem_req && dmem_ready in RUN: no freeze, zero-wait access.
- stall_cycles increments on every cycle with pc_write=0 and saturates at all-ones.
- An rst_n assertion mid-MEM_WAIT or in ERR returns everything to reset values immediately.

Decomposition:
- Package pipe_ctrl_pkg:
  - hc_state_t enum {RUN, MEM_WAIT, ERR}.
  - REG_X0 = 5'd0.
  - A NOP-control default struct, shared with the pipeline registers.
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, count), used for stall_cycles.
- The hazard logic stays in hazard_ctrl.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → 1 cycle of stall=1, pc_write=0, if_id_write=0; stall_cycles=1; next cycle all enables 1.
2. Load writing x0: ex_rd=0, id_rs1=0, id_use_rs1=1 → no stall. Also: ex_rd=5, id_rs2=5 with id_use_rs2=0 → no stall.
3. Branch vs load-use: ex_branch_taken=1 together with a load_use condition → if_id_flush=id_ex_flush=1, pc_write=1, stall=0.
4. Memory wait: mem_req=1 with dmem_ready low for 3 cycles then high → 4 frozen cycles with mem_wb_bubble=1; state back to RUN; stall_cycles=4.
5. Timeout with MEM_TIMEOUT=4: dmem_ready held low → mem_err=1 after 4 frozen cycles; freeze persists; rst_n pulse clears mem_err and stall_cycles to 0.
6. Branch during freeze: ex_branch_taken=1 while in MEM_WAIT → flushes=0 until dmem_ready, then flushes asserted for exactly 1 cycle. Also: CNT_W=4 with 20 stall cycles → stall_cycles=15.
